// File: rtl/uart_frame_pkg.sv
// Shared framing constants, framer state encoding and ASCII helpers for the
// UART frame transmitter and receive parser.
package uart_frame_pkg;

    localparam logic [7:0] STX = 8'h24;
    localparam logic [7:0] ETX = 8'h2A;
    localparam logic [7:0] SEP = 8'h2C;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STX,
        S_DATA,
        S_ETX,
        S_CKH,
        S_CKL,
        S_CR,
        S_LF
    } framer_state_t;

    // Uppercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
    function automatic logic [7:0] nib2hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic is_reserved(input logic [7:0] b);
        return (b == STX) || (b == ETX) || (b == CR) || (b == LF);
    endfunction

endpackage

// File: rtl/uart_tx_framer.sv
// Wraps a ready/valid payload stream as "$payload*HH\r\n" and writes it
// byte-by-byte into the UART TX FIFO, never writing while the FIFO is full.
module uart_tx_framer
    import uart_frame_pkg::*;
#(
    parameter bit ADD_CKSUM = 1'b1,
    parameter bit ADD_CRLF  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       UART_Full,
    output logic       UART_WR_EN,
    output logic [7:0] UART_Din,
    output logic       busy,
    output logic       frame_done,
    output logic       err_drop
);

    framer_state_t r_state;
    framer_state_t w_state_next;
    logic [7:0]    r_cksum;
    logic [7:0]    w_cksum_next;
    logic          r_frame_done;
    logic          w_frame_done_next;
    logic          r_err_drop;
    logic          w_err_drop_next;
    logic          w_handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cksum      <= 8'h00;
            r_frame_done <= 1'b0;
            r_err_drop   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cksum      <= w_cksum_next;
            r_frame_done <= w_frame_done_next;
            r_err_drop   <= w_err_drop_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cksum_next      = r_cksum;
        w_frame_done_next = 1'b0;
        w_err_drop_next   = 1'b0;
        in_ready          = 1'b0;
        UART_WR_EN        = 1'b0;
        UART_Din          = 8'h00;
        w_handshake       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The first payload byte only starts the frame; it is consumed in S_DATA.
                if (in_valid) begin
                    w_state_next = S_STX;
                    w_cksum_next = 8'h00;
                end
            end
            S_STX: begin
                UART_Din   = STX;
                UART_WR_EN = !UART_Full;
                if (!UART_Full) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready    = !UART_Full;
                w_handshake = in_valid && !UART_Full;
                if (w_handshake) begin
                    if (is_reserved(in_data)) begin
                        w_err_drop_next = 1'b1;
                    end else begin
                        UART_WR_EN   = 1'b1;
                        UART_Din     = in_data;
                        w_cksum_next = r_cksum ^ in_data;
                    end
                    if (in_last) begin
                        w_state_next = S_ETX;
                    end
                end
            end
            S_ETX: begin
                UART_Din   = ETX;
                UART_WR_EN = !UART_Full;
                if (!UART_Full) begin
                    if (ADD_CKSUM) begin
                        w_state_next = S_CKH;
                    end else if (ADD_CRLF) begin
                        w_state_next = S_CR;
                    end else begin
                        w_state_next      = S_IDLE;
                        w_frame_done_next = 1'b1;
                    end
                end
            end
            S_CKH: begin
                UART_Din   = nib2hex(r_cksum[7:4]);
                UART_WR_EN = !UART_Full;
                if (!UART_Full) begin
                    w_state_next = S_CKL;
                end
            end
            S_CKL: begin
                UART_Din   = nib2hex(r_cksum[3:0]);
                UART_WR_EN = !UART_Full;
                if (!UART_Full) begin
                    if (ADD_CRLF) begin
                        w_state_next = S_CR;
                    end else begin
                        w_state_next      = S_IDLE;
                        w_frame_done_next = 1'b1;
                    end
                end
            end
            S_CR: begin
                UART_Din   = CR;
                UART_WR_EN = !UART_Full;
                if (!UART_Full) begin
                    w_state_next = S_LF;
                end
            end
            S_LF: begin
                UART_Din   = LF;
                UART_WR_EN = !UART_Full;
                if (!UART_Full) begin
                    w_state_next      = S_IDLE;
                    w_frame_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign err_drop   = r_err_drop;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: expected FIFO bytes are queued when a
// frame is driven and compared as the framer writes them.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       UART_Full;
    logic       UART_WR_EN;
    logic [7:0] UART_Din;
    logic       busy;
    logic       frame_done;
    logic       err_drop;

    logic       bValid;
    logic [7:0] bData;
    logic       bLast;
    logic       bReady;
    logic       bFull;
    logic       bWrEn;
    logic [7:0] bDin;
    logic       bBusy;
    logic       bDone;
    logic       bDrop;

    int nCompared   = 0;
    int nMismatched = 0;
    int doneA       = 0;
    int dropA       = 0;
    int doneB       = 0;
    int dropB       = 0;

    logic [8:0] qA[$];
    logic [8:0] qB[$];
    logic [7:0] frm[$];

    always #5 clk = ~clk;

    uart_tx_framer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .UART_Full  (UART_Full),
        .UART_WR_EN (UART_WR_EN),
        .UART_Din   (UART_Din),
        .busy       (busy),
        .frame_done (frame_done),
        .err_drop   (err_drop)
    );

    uart_tx_framer #(.ADD_CKSUM(1'b0), .ADD_CRLF(1'b0)) dutBare (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (bValid),
        .in_data    (bData),
        .in_last    (bLast),
        .in_ready   (bReady),
        .UART_Full  (bFull),
        .UART_WR_EN (bWrEn),
        .UART_Din   (bDin),
        .busy       (bBusy),
        .frame_done (bDone),
        .err_drop   (bDrop)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the bytes in frm; the last one optionally marks the end of a frame.
    task automatic pushFrame(input bit toB, input bit markLast);
        for (int i = 0; i < frm.size(); i++) begin
            logic [8:0] e;
            e = {markLast && (i == frm.size() - 1), frm[i]};
            if (toB) qB.push_back(e);
            else qA.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic l);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("handshake", 32'(got), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while (qA.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("a_drain", 32'(qA.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic monitorA();
        logic [8:0] e;
        logic expDone;
        expDone = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done) doneA++;
            if (err_drop) dropA++;
            if (frame_done || expDone) checkOutput("a_frame_done", 32'(frame_done), 32'(expDone));
            expDone = 1'b0;
            if (UART_Full) checkOutput("a_wr_while_full", 32'(UART_WR_EN), 0);
            if (UART_WR_EN) begin
                if (qA.size() == 0) begin
                    checkOutput("a_unexpected_write", 32'(UART_Din), 32'h100);
                end else begin
                    e = qA.pop_front();
                    checkOutput("a_din", 32'(UART_Din), 32'(e[7:0]));
                    expDone = e[8];
                end
            end
        end
    endtask

    task automatic monitorB();
        logic [8:0] e;
        logic expDone;
        expDone = 1'b0;
        forever begin
            @(negedge clk);
            if (bDone) doneB++;
            if (bDrop) dropB++;
            if (bDone || expDone) checkOutput("b_frame_done", 32'(bDone), 32'(expDone));
            expDone = 1'b0;
            if (bWrEn) begin
                if (qB.size() == 0) begin
                    checkOutput("b_unexpected_write", 32'(bDin), 32'h100);
                end else begin
                    e = qB.pop_front();
                    checkOutput("b_din", 32'(bDin), 32'(e[7:0]));
                    expDone = e[8];
                end
            end
        end
    endtask

    initial begin
        int cycles;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        UART_Full = 1'b0;
        bValid    = 1'b0;
        bData     = 8'h00;
        bLast     = 1'b0;
        bFull     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_wr_en", 32'(UART_WR_EN), 0);
        checkOutput("rst_din", 32'(UART_Din), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_frame_done", 32'(frame_done), 0);
        checkOutput("rst_err_drop", 32'(err_drop), 0);
        rst = 1'b0;

        fork
            monitorA();
            monitorB();
        join_none

        $display("[TB] frame \"A,1\" with checksum and CRLF");
        frm = '{8'h24, 8'h41, 8'h2C, 8'h31, 8'h2A, 8'h35, 8'h43, 8'h0D, 8'h0A};
        pushFrame(1'b0, 1'b1);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h2C, 1'b0);
        applyStimulus(8'h31, 1'b1);
        waitDrain();
        checkOutput("t1_done_count", 32'(doneA), 1);

        $display("[TB] frame \"A,1\" without trailer options");
        frm = '{8'h24, 8'h41, 8'h2C, 8'h31, 8'h2A};
        pushFrame(1'b1, 1'b1);
        bValid = 1'b1;
        bData  = 8'h41;
        bLast  = 1'b0;
        cycles = 0;
        while (cycles < 30) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 3) begin
                bData = 8'h2C;
            end else if (cycles == 4) begin
                bData = 8'h31;
                bLast = 1'b1;
            end else if (cycles == 5) begin
                bValid = 1'b0;
                bLast  = 1'b0;
            end
            if (bDone) break;
        end
        checkOutput("b_latency", 32'(cycles), 6);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("b_done_count", 32'(doneB), 1);
        checkOutput("b_drain", 32'(qB.size()), 0);
        checkOutput("b_busy_idle", 32'(bBusy), 0);

        $display("[TB] frame \"12\" with back-pressure");
        frm = '{8'h24, 8'h31, 8'h32, 8'h2A, 8'h30, 8'h33, 8'h0D, 8'h0A};
        pushFrame(1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h31;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        UART_Full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("full_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        UART_Full = 1'b0;
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h32, 1'b1);
        @(posedge clk);
        #1;
        UART_Full = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        UART_Full = 1'b0;
        waitDrain();
        checkOutput("t3_done_count", 32'(doneA), 2);

        $display("[TB] reserved byte inside payload");
        frm = '{8'h24, 8'h41, 8'h42, 8'h2A, 8'h30, 8'h33, 8'h0D, 8'h0A};
        pushFrame(1'b0, 1'b1);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h2A, 1'b0);
        applyStimulus(8'h42, 1'b1);
        waitDrain();
        checkOutput("t4_drop_count", 32'(dropA), 1);
        checkOutput("t4_done_count", 32'(doneA), 3);

        $display("[TB] frame whose only byte is dropped");
        frm = '{8'h24, 8'h2A, 8'h30, 8'h30, 8'h0D, 8'h0A};
        pushFrame(1'b0, 1'b1);
        applyStimulus(8'h0D, 1'b1);
        waitDrain();
        checkOutput("t5_drop_count", 32'(dropA), 2);
        checkOutput("t5_done_count", 32'(doneA), 4);

        $display("[TB] reset in the middle of a payload");
        frm = '{8'h24, 8'h41, 8'h42};
        pushFrame(1'b0, 1'b0);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h42, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_busy_after_rst", 32'(busy), 0);
        checkOutput("t6_written", 32'(qA.size()), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        frm = '{8'h24, 8'h5A, 8'h2A, 8'h35, 8'h41, 8'h0D, 8'h0A};
        pushFrame(1'b0, 1'b1);
        applyStimulus(8'h5A, 1'b1);
        waitDrain();
        checkOutput("t6_done_count", 32'(doneA), 5);

        $display("[TB] back-to-back frames \"X\" and \"Y\"");
        frm = '{8'h24, 8'h58, 8'h2A, 8'h35, 8'h38, 8'h0D, 8'h0A};
        pushFrame(1'b0, 1'b1);
        frm = '{8'h24, 8'h59, 8'h2A, 8'h35, 8'h39, 8'h0D, 8'h0A};
        pushFrame(1'b0, 1'b1);
        applyStimulus(8'h58, 1'b1);
        applyStimulus(8'h59, 1'b1);
        waitDrain();
        checkOutput("t7_done_count", 32'(doneA), 7);
        checkOutput("final_drop_count", 32'(dropA), 2);
        checkOutput("b_drop_count", 32'(dropB), 0);
        checkOutput("final_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
